load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU. Consumes the ALU result as the effective address for RV32I loads and stores.
- Performs byte/halfword lane steering, write strobes and load sign/zero extension.
- Runs a valid/ready request to data memory and stalls the single-cycle core until the access completes.
- Detects misaligned addresses and illegal funct3 encodings and reports them as faults.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module     : load_store_unit_if
// Description: Bundle of core-side and data-memory-side signals of the
//              load/store unit.
//                core -> lsu : start, mem_write, funct3, addr, wdata
//                lsu -> core : stall, done, rdata, err
//                lsu -> mem  : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//                mem -> lsu  : mem_rdata, mem_ready
//              master = environment (core + memory), slave = the LSU.
// Revision   : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mem_write;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output start, mem_write, funct3, addr, wdata, mem_rdata, mem_ready,
    input  stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  start, mem_write, funct3, addr, wdata, mem_rdata, mem_ready,
    output stall, done, rdata, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module     : load_store_unit
// Description: RV32I memory-access stage. Takes the ALU result as effective
//              address, steers byte/halfword lanes, generates write strobes,
//              sign/zero-extends loads, runs a valid/ready request to data
//              memory and stalls the core until the access completes.
//              Misaligned or illegal accesses finish immediately with err.
// Ports      : clk   - system clock, rising edge
//              reset - asynchronous active-high reset
//              bus   - load_store_unit_if.slave (core and memory signals)
// Revision   : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_q;

  logic             fault_d;
  logic [3:0]       wstrb_d;
  logic [WIDTH-1:0] wdata_d;
  logic [WIDTH-1:0] rdata_d;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  // Fault classification of the instruction presented this cycle.
  always_comb begin
    fault_d = 1'b0;
    case (bus.funct3)
      3'b000:         fault_d = 1'b0;
      3'b001:         fault_d = bus.addr[0];
      3'b010:         fault_d = (bus.addr[1:0] != 2'b00);
      3'b100:         fault_d = bus.mem_write;
      3'b101:         fault_d = bus.mem_write | bus.addr[0];
      default:        fault_d = 1'b1;
    endcase
  end

  // Store lane steering: data is replicated across the word so the byte
  // enables alone pick the lane memory actually writes.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = bus.wdata;
    if (bus.mem_write) begin
      case (bus.funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << bus.addr[1:0];
          wdata_d = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = bus.addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = bus.wdata;
        end
      endcase
    end
  end

  // Load lane selection and extension, using the registered offset/funct3.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  rdata_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  rdata_d = {24'd0, lane_b};
      3'b001:  rdata_d = {{16{lane_h[15]}}, lane_h};
      3'b101:  rdata_d = {16'd0, lane_h};
      default: rdata_d = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.start) begin
            if (fault_d) begin
              // No memory traffic; report the fault on the next cycle.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= REQ;
              is_store_q  <= bus.mem_write;
              funct3_q    <= bus.funct3;
              off_q       <= bus.addr[1:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.mem_write;
              mem_addr_q  <= {bus.addr[WIDTH-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= wstrb_d;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            state_q     <= DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            if (!is_store_q) begin
              rdata_q <= rdata_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must reach the PC in the same cycle start appears.
  assign bus.stall     = ((state_q == IDLE) & bus.start) | (state_q == REQ);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_load_store_unit
// Description: Scoreboard bench for load_store_unit. The driver issues
//              instructions and pushes expected memory requests and
//              completions; a monitor compares them whenever the DUT shows
//              mem_req or done.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  req_t  req_q[$];
  resp_t resp_q[$];
  logic [31:0] model_rdata = 32'd0;

  load_store_unit_if #(.WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((a % size_of(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = d >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic req_t store_req(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd);
    req_t r;
    int   sz;
    int   off;
    sz      = size_of(f3);
    off     = a % 4;
    r.we    = 1'b1;
    r.addr  = a - off;
    r.wstrb = 4'b0000;
    r.wdata = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + sz) r.wstrb[b] = 1'b1;
      r.wdata[8*b +: 8] = wd[8*(b % sz) +: 8];
    end
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (resp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("done_err", {31'd0, bus.err}, {31'd0, e.err});
          chk("done_rdata", bus.rdata, e.rdata);
        end
      end
      if (bus.mem_req) begin
        if (req_q.size() == 0) begin
          chk("spurious_mem_req", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = req_q[0];
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, e.wstrb});
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
          if (bus.mem_ready) void'(req_q.pop_front());
        end
      end else if (bus.mem_wstrb !== 4'b0000) begin
        chk("idle_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at 1 time unit after a rising edge with the DUT in IDLE.
  task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] md, input int w,
                    input bit hold, input int abort_at);
    bit    f;
    resp_t rs;
    f = is_fault(we, f3, a);
    bus.start     = 1'b1;
    bus.mem_write = we;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_rdata = md;
    if (!f) begin
      if (we) begin
        req_q.push_back(store_req(f3, a, wd));
      end else begin
        req_t r;
        r.we = 1'b0; r.addr = a & 32'hFFFF_FFFC; r.wdata = 32'd0; r.wstrb = 4'b0000;
        req_q.push_back(r);
        model_rdata = load_val(f3, a, md);
      end
    end
    rs.err   = f;
    rs.rdata = model_rdata;
    resp_q.push_back(rs);
    #1 chk("stall_start", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    if (!f) begin
      for (int k = 0; k <= w; k++) begin
        bus.mem_ready = (k == w);
        if (k == abort_at) begin
          bus.mem_ready = 1'b0;
          #1 reset = 1'b1;
          #1;
          chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
          chk("abort_stall", {31'd0, bus.stall}, 32'd0);
          chk("abort_done", {31'd0, bus.done}, 32'd0);
          req_q.delete();
          resp_q.delete();
          model_rdata = 32'd0;
          bus.start = 1'b0;
          @(posedge clk); #1 reset = 1'b0;
          return;
        end
        #1 chk("stall_req", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
    end
    #1 chk("stall_done", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // SW, zero wait states
    op(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0, 1'b0, -1);
    // LB / LBU of the top byte
    op(1'b0, 3'b000, 32'h0000_0013, 32'd0, 32'h80FF_0000, 0, 1'b0, -1);
    chk("lb_value", model_rdata, 32'hFFFF_FF80);
    op(1'b0, 3'b100, 32'h0000_0013, 32'd0, 32'h80FF_0000, 1, 1'b0, -1);
    // SH upper half with 3 wait states
    op(1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234, 32'd0, 3, 1'b0, -1);
    // Faults: misaligned LW, illegal funct3, store with unsigned funct3
    op(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'h5555_5555, 0, 1'b0, -1);
    op(1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'h5555_5555, 0, 1'b0, -1);
    op(1'b1, 3'b100, 32'h0000_0000, 32'h1, 32'd0, 0, 1'b0, -1);
    // Reset in the second wait cycle of a request, then normal LW
    op(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 3, 1'b0, 1);
    chk("post_abort_rdata", bus.rdata, 32'd0);
    op(1'b0, 3'b010, 32'h0000_0008, 32'd0, 32'h0102_0304, 0, 1'b0, -1);
    // start held through REQ/DONE, then mem_ready pulsed while idle
    op(1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'h8765_4321, 2, 1'b1, -1);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op($urandom_range(0, 1), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
         $urandom, $urandom, $urandom_range(0, 3), bit'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("req_queue_drained", req_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
